// File: rtl/ysyx_23060236_clint_mh.sv
`timescale 1ns/1ps
// Multi-hart core-local interruptor: prescaled 64-bit mtime, per-hart mtimecmp/msip, AXI4-Lite-style slave.
// Optional: define YSYX_23060236_CLINT_HI_SNAPSHOT_EN to latch mtime[63:32] on low-word reads.
module ysyx_23060236_clint_mh #(
   parameter int NHART    = 1,
   parameter int PRESCALE = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      araddr,
   input  logic             arvalid,
   output logic             arready,
   output logic [31:0]      rdata,
   output logic [1:0]       rresp,
   output logic             rvalid,
   input  logic             rready,
   input  logic [31:0]      awaddr,
   input  logic             awvalid,
   output logic             awready,
   input  logic [31:0]      wdata,
   input  logic [3:0]       wstrb,
   input  logic             wvalid,
   output logic             wready,
   output logic [1:0]       bresp,
   output logic             bvalid,
   input  logic             bready,
   output logic [NHART-1:0] mtip,
   output logic [NHART-1:0] msip
);

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [15:0] PRESC_LAST  = 16'(PRESCALE - 1);

   typedef enum logic {R_IDLE, R_RESP} rstate_e;
   typedef enum logic {W_IDLE, W_RESP} wstate_e;
   typedef enum logic [2:0] {A_MSIP, A_CMPLO, A_CMPHI, A_MTLO, A_MTHI, A_ERR} sel_e;

   // Classify a 16-bit offset; unmapped, misaligned or out-of-range hart offsets fall to A_ERR.
   function automatic sel_e f_sel(input logic [15:0] a);
      sel_e s;
      s = A_ERR;
      if (a[1:0] == 2'b00) begin
         if (a[15:6] == 10'h000 && int'(a[5:2]) < NHART)
            s = A_MSIP;
         else if (a[15:7] == 9'h080 && int'(a[6:3]) < NHART)
            s = a[2] ? A_CMPHI : A_CMPLO;
         else if (a == 16'hBFF8)
            s = A_MTLO;
         else if (a == 16'hBFFC)
            s = A_MTHI;
      end
      return s;
   endfunction

   function automatic logic [3:0] f_hart(input logic [15:0] a);
      return (a[15:14] == 2'b01) ? a[6:3] : a[5:2];
   endfunction

   function automatic logic [31:0] f_merge(input logic [31:0] cur,
                                          input logic [31:0] nw,
                                          input logic [3:0]  strb);
      logic [31:0] m;
      for (int b = 0; b < 4; b++)
         m[8*b +: 8] = strb[b] ? nw[8*b +: 8] : cur[8*b +: 8];
      return m;
   endfunction

   rstate_e          r_rstate, w_rstate_nxt;
   wstate_e          r_wstate, w_wstate_nxt;
   logic [15:0]      r_presc;
   logic             w_tick;
   logic [63:0]      r_mtime;
   logic [63:0]      r_mtimecmp [NHART];
   logic [NHART-1:0] r_msip;
   logic [NHART-1:0] r_mtip;
   logic [31:0]      r_rdata;
   logic [1:0]       r_rresp;
   logic [1:0]       r_bresp;
   logic             r_aw_held;
   logic             r_w_held;
   logic [15:0]      r_awaddr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wstrb;
   logic             w_ar_fire;
   logic             w_aw_fire;
   logic             w_w_fire;
   logic             w_b_fire;
   logic             w_commit;
   logic             w_wr_mtlo;
   logic             w_wr_mthi;
   sel_e             w_rd_sel;
   sel_e             w_wr_sel;
   logic [3:0]       w_rd_hart;
   logic [3:0]       w_wr_hart;
   logic [31:0]      w_rd_data;
   logic             w_rd_err;
   logic             w_unused;

`ifdef YSYX_23060236_CLINT_HI_SNAPSHOT_EN
   logic [31:0]      r_shadow;
`endif

   assign w_unused = ^{araddr[31:16], awaddr[31:16]};

   // Read FSM
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_rstate <= R_IDLE;
      else        r_rstate <= w_rstate_nxt;
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_fire) w_rstate_nxt = R_RESP;
         R_RESP:  if (rready)    w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      arready = (r_rstate == R_IDLE);
      rvalid  = (r_rstate == R_RESP);
   end

   assign w_ar_fire = arvalid & arready;
   assign w_rd_sel  = f_sel(araddr[15:0]);
   assign w_rd_hart = f_hart(araddr[15:0]);

   always_comb begin
      w_rd_data = '0;
      w_rd_err  = 1'b0;
      case (w_rd_sel)
         A_MSIP: begin
            for (int h = 0; h < NHART; h++)
               if (w_rd_hart == 4'(h)) w_rd_data = {31'b0, r_msip[h]};
         end
         A_CMPLO: begin
            for (int h = 0; h < NHART; h++)
               if (w_rd_hart == 4'(h)) w_rd_data = r_mtimecmp[h][31:0];
         end
         A_CMPHI: begin
            for (int h = 0; h < NHART; h++)
               if (w_rd_hart == 4'(h)) w_rd_data = r_mtimecmp[h][63:32];
         end
         A_MTLO:  w_rd_data = r_mtime[31:0];
`ifdef YSYX_23060236_CLINT_HI_SNAPSHOT_EN
         A_MTHI:  w_rd_data = r_shadow;
`else
         A_MTHI:  w_rd_data = r_mtime[63:32];
`endif
         default: w_rd_err = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_fire) begin
         r_rdata <= w_rd_data;
         r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end
   end

   assign rdata = r_rdata;
   assign rresp = r_rresp;

   // Write FSM: address and data are collected independently, then commit in W_IDLE
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_wstate <= W_IDLE;
      else        r_wstate <= w_wstate_nxt;
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
         W_RESP:  if (bready)   w_wstate_nxt = W_IDLE;
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      awready = (r_wstate == W_IDLE) & ~r_aw_held;
      wready  = (r_wstate == W_IDLE) & ~r_w_held;
      bvalid  = (r_wstate == W_RESP);
   end

   assign w_aw_fire = awvalid & awready;
   assign w_w_fire  = wvalid & wready;
   assign w_b_fire  = bvalid & bready;
   assign w_commit  = (r_wstate == W_IDLE) & r_aw_held & r_w_held;
   assign w_wr_sel  = f_sel(r_awaddr);
   assign w_wr_hart = f_hart(r_awaddr);
   assign w_wr_mtlo = w_commit & (w_wr_sel == A_MTLO);
   assign w_wr_mthi = w_commit & (w_wr_sel == A_MTHI);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
      end else begin
         if (w_b_fire)       r_aw_held <= 1'b0;
         else if (w_aw_fire) r_aw_held <= 1'b1;
         if (w_b_fire)       r_w_held  <= 1'b0;
         else if (w_w_fire)  r_w_held  <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (w_aw_fire) r_awaddr <= awaddr[15:0];
      if (w_w_fire) begin
         r_wdata <= wdata;
         r_wstrb <= wstrb;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)        r_bresp <= RESP_OKAY;
      else if (w_commit) r_bresp <= (w_wr_sel == A_ERR) ? RESP_SLVERR : RESP_OKAY;
   end

   assign bresp = r_bresp;

   // Timebase: a write to either mtime word replaces that cycle's tick and never carries
   assign w_tick = (r_presc == PRESC_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_presc <= '0;
      else        r_presc <= w_tick ? '0 : r_presc + 16'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)         r_mtime <= '0;
      else if (w_wr_mtlo) r_mtime[31:0]  <= f_merge(r_mtime[31:0], r_wdata, r_wstrb);
      else if (w_wr_mthi) r_mtime[63:32] <= f_merge(r_mtime[63:32], r_wdata, r_wstrb);
      else if (w_tick)    r_mtime <= r_mtime + 64'd1;
   end

`ifdef YSYX_23060236_CLINT_HI_SNAPSHOT_EN
   // A low-word read wins over a same-cycle high write so the snapshot pairs with the returned low word.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                r_shadow <= '0;
      else if (w_ar_fire && w_rd_sel == A_MTLO)  r_shadow <= r_mtime[63:32];
      else if (w_wr_mthi)                        r_shadow <= f_merge(r_mtime[63:32], r_wdata, r_wstrb);
   end
`endif

   // Per-hart compare and software-interrupt state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int h = 0; h < NHART; h++) r_mtimecmp[h] <= '1;
      end else if (w_commit) begin
         for (int h = 0; h < NHART; h++) begin
            if (w_wr_hart == 4'(h) && w_wr_sel == A_CMPLO)
               r_mtimecmp[h][31:0] <= f_merge(r_mtimecmp[h][31:0], r_wdata, r_wstrb);
            if (w_wr_hart == 4'(h) && w_wr_sel == A_CMPHI)
               r_mtimecmp[h][63:32] <= f_merge(r_mtimecmp[h][63:32], r_wdata, r_wstrb);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_msip <= '0;
      end else if (w_commit && w_wr_sel == A_MSIP && r_wstrb[0]) begin
         for (int h = 0; h < NHART; h++)
            if (w_wr_hart == 4'(h)) r_msip[h] <= r_wdata[0];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_mtip <= '0;
      end else begin
         for (int h = 0; h < NHART; h++)
            r_mtip[h] <= (r_mtime >= r_mtimecmp[h]);
      end
   end

   assign mtip = r_mtip;
   assign msip = r_msip;

endmodule

// File: tb/tb_ysyx_23060236_clint_mh.sv
`timescale 1ns/1ps
// Directed bench for ysyx_23060236_clint_mh with NHART=2, PRESCALE=4.
module tb_ysyx_23060236_clint_mh;

   localparam int NHART = 2;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [31:0]      araddr;
   logic             arvalid;
   logic             arready;
   logic [31:0]      rdata;
   logic [1:0]       rresp;
   logic             rvalid;
   logic             rready;
   logic [31:0]      awaddr;
   logic             awvalid;
   logic             awready;
   logic [31:0]      wdata;
   logic [3:0]       wstrb;
   logic             wvalid;
   logic             wready;
   logic [1:0]       bresp;
   logic             bvalid;
   logic             bready;
   logic [NHART-1:0] mtip;
   logic [NHART-1:0] msip;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   ysyx_23060236_clint_mh #(.NHART(NHART), .PRESCALE(4)) u_dut (
      .clock   (clock),
      .reset   (reset),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready),
      .mtip    (mtip),
      .msip    (msip)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r);
      int n;
      @(negedge clock);
      araddr  = {16'h0200, a};
      arvalid = 1'b1;
      rready  = 1'b1;
      n = 0;
      while (!arready && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("rd_arready", arready, 1);
      check("rd_rvalid_pre", rvalid, 0);
      @(posedge clock);
      #1;
      arvalid = 1'b0;
      check("rd_rvalid_lat", rvalid, 1);
      d = rdata;
      r = rresp;
      @(posedge clock);
      #1;
      rready = 1'b0;
   endtask

   task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r);
      int n;
      @(negedge clock);
      awaddr  = {16'h0200, a};
      wdata   = d;
      wstrb   = s;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b1;
      check("wr_ready", awready & wready, 1);
      @(posedge clock);
      #1;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin
         @(posedge clock);
         #1;
         n++;
      end
      check("wr_bvalid", bvalid, 1);
      r = bresp;
      @(posedge clock);
      #1;
      bready = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: no finish by time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [31:0] d;
      logic [1:0]  r;
      int          n;
      int          nb;

      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      check("rst_arready", arready, 1);
      check("rst_awready", awready, 1);
      check("rst_wready", wready, 1);
      check("rst_rvalid", rvalid, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rresp", rresp, 0);
      check("rst_bresp", bresp, 0);
      check("rst_mtip", mtip, 0);
      check("rst_msip", msip, 0);
      @(negedge clock);
      reset = 1'b1;

      // 40 edges at PRESCALE=4 -> mtime 10 at the accepting edge
      repeat (40) @(posedge clock);
      axi_read(16'hBFF8, d, r);
      check("mtime_40cyc", d, 32'd10);
      check("mtime_rresp", r, 2'b00);

      axi_read(16'h4008, d, r);
      check("cmp1_lo_rst", d, 32'hFFFF_FFFF);
      axi_read(16'h400C, d, r);
      check("cmp1_hi_rst", d, 32'hFFFF_FFFF);

      axi_write(16'h4004, 32'h0, 4'hF, r);
      check("cmp0_hi_bresp", r, 2'b00);
      axi_write(16'h4000, 32'h20, 4'hF, r);
      check("cmp0_lo_bresp", r, 2'b00);
      check("mtip0_pre", mtip[0], 0);

      n = 0;
      while (!mtip[0] && n < 400) begin
         @(negedge clock);
         n++;
      end
      check("mtip0_rise", mtip[0], 1);
      axi_read(16'hBFF8, d, r);
      check("mtip0_mtime", d, 32'h20);
      check("mtip1_low", mtip[1], 0);

      axi_write(16'h4000, 32'hFFFF_FFFF, 4'hF, r);
      check("cmp0_clr_bresp", r, 2'b00);
      check("mtip0_fall", mtip[0], 0);

      axi_write(16'h0004, 32'h3, 4'hF, r);
      check("msip1_bresp", r, 2'b00);
      check("msip_vec", msip, 2'b10);
      axi_read(16'h0004, d, r);
      check("msip1_rd", d, 32'h1);
      check("msip1_rresp", r, 2'b00);
      axi_write(16'h0008, 32'h1, 4'hF, r);
      check("msip2_bresp", r, 2'b10);
      check("msip_vec_keep", msip, 2'b10);
      axi_read(16'h0008, d, r);
      check("msip2_rd", d, 32'h0);
      check("msip2_rresp", r, 2'b10);
      axi_read(16'h0002, d, r);
      check("misalign_rresp", r, 2'b10);

      // Only byte0 of a small mtime low word is replaced
      axi_write(16'hBFF8, 32'hFFFF_FFFF, 4'h1, r);
      check("mt_strb_bresp", r, 2'b00);
      axi_read(16'hBFF8, d, r);
      check($sformatf("mt_strb_lo_%0h", d), (d == 32'hFF || d == 32'h100), 1);
      axi_read(16'hBFFC, d, r);
      check("mt_hi_zero", d, 32'h0);

      axi_write(16'hBFFC, 32'h0, 4'hF, r);
      check("mt_hi_bresp", r, 2'b00);
      axi_write(16'hBFF8, 32'hFFFF_FFF0, 4'hF, r);
      axi_read(16'hBFF8, d, r);
      check($sformatf("mt_lo_near_%0h", d), (d == 32'hFFFF_FFF0 || d == 32'hFFFF_FFF1), 1);
      axi_read(16'hBFFC, d, r);
      check("mt_hi_nocarry", d, 32'h0);
      repeat (80) @(posedge clock);
      axi_read(16'hBFFC, d, r);
      check("mt_hi_carry", d, 32'h1);
      axi_read(16'hBFF8, d, r);
      check($sformatf("mt_lo_wrapped_%0h", d), (d < 32'h20), 1);

      @(negedge clock);
      araddr  = 32'h0000_0004;
      arvalid = 1'b1;
      rready  = 1'b0;
      @(posedge clock);
      #1;
      arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_rvalid", rvalid, 1);
         check("stall_rdata", rdata, 32'h1);
         check("stall_arready", arready, 0);
         @(posedge clock);
         #1;
      end
      rready = 1'b1;
      @(posedge clock);
      #1;
      rready = 1'b0;
      check("stall_release", rvalid, 0);

      // Address leads data by three cycles
      @(negedge clock);
      awaddr  = 32'h0000_0000;
      awvalid = 1'b1;
      wdata   = 32'h1;
      wstrb   = 4'h1;
      bready  = 1'b1;
      @(posedge clock);
      #1;
      check("split_awready", awready, 0);
      check("split_wready", wready, 1);
      repeat (2) @(posedge clock);
      @(negedge clock);
      wvalid = 1'b1;
      @(posedge clock);
      #1;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock);
         #1;
         if (bvalid) nb++;
      end
      bready = 1'b0;
      check("split_one_b", nb, 1);
      check("split_msip", msip, 2'b11);

      @(negedge clock);
      araddr  = 32'h0000_0004;
      arvalid = 1'b1;
      rready  = 1'b0;
      awaddr  = 32'h0000_4000;
      wdata   = 32'h1234;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b0;
      @(posedge clock);
      #1;
      arvalid = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      @(posedge clock);
      #1;
      check("pre_rst_rvalid", rvalid, 1);
      check("pre_rst_bvalid", bvalid, 1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_rvalid", rvalid, 0);
      check("arst_bvalid", bvalid, 0);
      check("arst_arready", arready, 1);
      check("arst_awready", awready, 1);
      check("arst_msip", msip, 0);
      @(negedge clock);
      reset = 1'b1;
      axi_read(16'h4000, d, r);
      check("arst_cmp0_lo", d, 32'hFFFF_FFFF);
      axi_read(16'h4004, d, r);
      check("arst_cmp0_hi", d, 32'hFFFF_FFFF);
      axi_read(16'hBFFC, d, r);
      check("arst_mt_hi", d, 32'h0);
      check("arst_mtip", mtip, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
